cycle_timer: RTL and testbench
==============================

CYCLE_TIMER -- requirements
Module: cycle_timer

Interface
REQ-001 SHALL have parameter PH_W, default 6: width of phase counter and cycle-length entries.
REQ-002 SHALL have parameter CYC_W, default 16: width of completed-cycle counter.
REQ-003 SHALL have parameter WP_LEN, default 4: write-pulse length in clk ticks.
REQ-004 SHALL have parameter LEN_TABLE, default {15,23,17,25,20,28,32,32} (entries 7..0, PH_W bits each, clk ticks): cycle length per index {sspeed,ilong}.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 clock_reset_b  in  1  reset, asynchronous, active-low.
REQ-007 sspeed  in  2  speed select, bits [1:0].
REQ-008 ilong  in  1  long-instruction select; index = {sspeed[1],sspeed[0],ilong}.
REQ-009 machrun  in  1  free-run enable.
REQ-010 step  in  1  single-cycle request strobe, one clk wide.
REQ-011 hang  in  1  stall request; extends the current cycle at its last phase.
REQ-012 tpclk  out  1  processor clock phase.
REQ-013 tprend  out  1  one-tick end-of-cycle strobe.
REQ-014 tpwp  out  1  write pulse.
REQ-015 running  out  1  high while a cycle is in progress.
REQ-016 phase  out  PH_W  current phase within cycle.
REQ-017 cycle_cnt  out  CYC_W  completed cycles, wraps modulo 2^CYC_W.

Function
REQ-018 States SHALL be IDLE, RUN, HOLD; running = (state != IDLE).
REQ-019 IDLE->RUN SHALL occur on the tick where machrun=1 or step=1; phase loads 0 and L = LEN_TABLE[index] is latched.
REQ-020 Latched L SHALL be fixed for the whole cycle; sspeed or ilong changes take effect at the next cycle start only.
REQ-021 In RUN, phase SHALL increment by 1 per tick up to L-1.
REQ-022 tpclk SHALL be 1 for phases 0..(L>>1)-1 while running, else 0.
REQ-023 At phase L-1 with hang=0, tprend SHALL be 1 for that tick only, and cycle_cnt SHALL increment on the following edge.
REQ-024 At phase L-1 with hang=1, the block SHALL enter HOLD; phase holds at L-1, tprend=0.
REQ-025 HOLD SHALL persist while hang=1; on the first tick with hang=0, tprend=1 and the cycle completes as in REQ-023.
REQ-026 hang at phases other than L-1 SHALL be ignored.
REQ-027 After cycle completion, the block SHALL start the next cycle at phase 0 if machrun=1, else go to IDLE with phase=0.
REQ-028 Dropping machrun mid-cycle SHALL let the current cycle complete, then go to IDLE.
REQ-029 step while running SHALL be ignored; step with machrun=1 in IDLE SHALL give a single start, continuing as free run.
REQ-030 tpwp SHALL be 1 for phases 1..WP_LEN of any cycle whose start tick saw machrun=1 or step=1; 0 otherwise, including in HOLD.
REQ-031 Table entries SHALL satisfy L >= WP_LEN+2 and L >= 2; behaviour for violating entries is unspecified.

Reset
REQ-032 While clock_reset_b=0, the block SHALL be in state IDLE with phase=0, cycle_cnt=0, and tpclk, tprend, tpwp and running all 0, asynchronously.
REQ-033 Reset asserted mid-cycle or in HOLD SHALL abort the cycle immediately, with no tprend and no count.
REQ-034 After deassertion, the first start SHALL follow REQ-019 on a later edge.

Structure
REQ-035 Package cycle_timer_pkg SHALL hold the state encoding, default LEN_TABLE entries and default WP_LEN.
REQ-036 No sub-module is required; the length lookup MAY be a function in the package.

Verification
REQ-037 Reset, then machrun=1, sspeed=0, ilong=0 -> tprend every 32 ticks; tpclk high 16 ticks; tpwp high at phases 1..4; cycle_cnt=3 after 96 ticks.
REQ-038 Change to sspeed=3, ilong=1 at phase 10 -> current cycle stays 32 ticks; next cycles are 15 ticks with tpclk high for 7.
REQ-039 hang=1 from phase 5 through 20 ticks past phase L-1 -> phase frozen at L-1, tprend=0 and tpwp=0 during hold; tprend one tick after hang falls; cycle length = L+20.
REQ-040 machrun=0, step pulse, index 4 (L=25) -> exactly one 25-tick cycle, one tprend, cycle_cnt +1, then IDLE; a second step mid-cycle is ignored.
REQ-041 clock_reset_b low at phase 12 -> all outputs 0 the same tick, cycle_cnt=0; restart gives a full cycle from phase 0.
REQ-042 CYC_W=4, run 17 cycles of L=15 -> cycle_cnt wraps to 1.

Source files
------------

// File: rtl/cycle_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cycle_timer_pkg
// Description : State encoding, default cycle-length table and write-pulse
//               length shared by the cycle timer.
// Revision    : 1.0 - initial release
// ============================================================================
package cycle_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int DEF_PH_W   = 6;
    localparam int DEF_WP_LEN = 4;

    // Entries 7..0, indexed by {sspeed, ilong}
    localparam logic [8*DEF_PH_W-1:0] DEF_LEN_TABLE = {
        6'd15, 6'd23, 6'd17, 6'd25, 6'd20, 6'd28, 6'd32, 6'd32
    };

    function automatic logic [2:0] len_index(input logic [1:0] sspeed, input logic ilong);
        return {sspeed, ilong};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cycle_timer.sv
`default_nettype none
// ============================================================================
// Module      : cycle_timer
// Description : Processor cycle sequencer producing clock phase, end-of-cycle
//               strobe and write pulse with stall (hang) support.
// Revision    : 1.0 - initial release
// ============================================================================
module cycle_timer
    import cycle_timer_pkg::*;
#(
    parameter int                PH_W      = DEF_PH_W,
    parameter int                CYC_W     = 16,
    parameter int                WP_LEN    = DEF_WP_LEN,
    parameter logic [8*PH_W-1:0] LEN_TABLE = DEF_LEN_TABLE
)(
    input  logic             clk,
    input  logic             clock_reset_b,
    input  logic [1:0]       sspeed,
    input  logic             ilong,
    input  logic             machrun,
    input  logic             step,
    input  logic             hang,
    output logic             tpclk,
    output logic             tprend,
    output logic             tpwp,
    output logic             running,
    output logic [PH_W-1:0]  phase,
    output logic [CYC_W-1:0] cycle_cnt
);

    localparam logic [PH_W-1:0] c_wp_len = PH_W'(WP_LEN);
    localparam logic [PH_W-1:0] c_one    = PH_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PH_W-1:0]  r_phase;
    logic [PH_W-1:0]  r_len;
    logic [CYC_W-1:0] r_cnt;
    logic [2:0]       w_idx;
    logic [PH_W-1:0]  w_sel_len;
    logic             w_at_last;
    logic             w_start;
    logic             w_done;

    assign w_idx     = len_index(sspeed, ilong);
    assign w_sel_len = LEN_TABLE[int'(w_idx)*PH_W +: PH_W];
    assign w_at_last = (r_phase == (r_len - c_one));

    always_ff @(posedge clk or negedge clock_reset_b) begin
        if (!clock_reset_b) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        tprend      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (machrun || step) begin
                    w_state_nxt = ST_RUN;
                    w_start     = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_at_last) begin
                    if (hang) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        tprend = 1'b1;
                        w_done = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (!hang) begin
                    tprend = 1'b1;
                    w_done = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Back-to-back cycles only continue under free run; step is ignored here
        if (w_done) begin
            if (machrun) begin
                w_state_nxt = ST_RUN;
                w_start     = 1'b1;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge clock_reset_b) begin
        if (!clock_reset_b) begin
            r_phase <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_start) begin
                r_phase <= '0;
                r_len   <= w_sel_len;
            end else if (w_done) begin
                r_phase <= '0;
            end else if (r_state == ST_RUN && !w_at_last) begin
                r_phase <= r_phase + c_one;
            end
            if (w_done) begin
                r_cnt <= r_cnt + CYC_W'(1);
            end
        end
    end

    assign running   = (r_state != ST_IDLE);
    assign phase     = r_phase;
    assign cycle_cnt = r_cnt;
    assign tpclk     = running && (r_phase < (r_len >> 1));
    assign tpwp      = (r_state == ST_RUN) && (r_phase != '0) && (r_phase <= c_wp_len);

endmodule
`default_nettype wire

// File: tb/tb_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cycle_timer
// Description : Directed scoreboard bench for cycle_timer; a monitor checks
//               every completed cycle against queued expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cycle_timer;

    logic        clk = 1'b0;
    logic        clock_reset_b;
    logic [1:0]  sspeed;
    logic        ilong;
    logic        machrun;
    logic        step;
    logic        hang;
    logic        tpclk;
    logic        tprend;
    logic        tpwp;
    logic        running;
    logic [5:0]  phase;
    logic [15:0] cycle_cnt;

    logic        wr_rst_b;
    logic        wr_machrun;
    logic        wr_tpclk;
    logic        wr_tprend;
    logic        wr_tpwp;
    logic        wr_running;
    logic [5:0]  wr_phase;
    logic [3:0]  wr_cnt;

    always #5 clk = ~clk;

    cycle_timer u_dut (
        .clk           (clk),
        .clock_reset_b (clock_reset_b),
        .sspeed        (sspeed),
        .ilong         (ilong),
        .machrun       (machrun),
        .step          (step),
        .hang          (hang),
        .tpclk         (tpclk),
        .tprend        (tprend),
        .tpwp          (tpwp),
        .running       (running),
        .phase         (phase),
        .cycle_cnt     (cycle_cnt)
    );

    cycle_timer #(.CYC_W(4)) u_wrap (
        .clk           (clk),
        .clock_reset_b (wr_rst_b),
        .sspeed        (2'b11),
        .ilong         (1'b1),
        .machrun       (wr_machrun),
        .step          (1'b0),
        .hang          (1'b0),
        .tpclk         (wr_tpclk),
        .tprend        (wr_tprend),
        .tpwp          (wr_tpwp),
        .running       (wr_running),
        .phase         (wr_phase),
        .cycle_cnt     (wr_cnt)
    );

    typedef struct {
        int len;
        int clk_hi;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int len, input int clk_hi, input int cnt);
        exp_t e;
        e.len    = len;
        e.clk_hi = clk_hi;
        e.cnt    = cnt;
        sb.push_back(e);
    endtask

    // kind 0: phase==val, 1: cycle_cnt==val, 2: idle
    task automatic wait_for(input string what, input int kind, input int val);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if ((kind == 0 && int'(phase) == val) ||
                (kind == 1 && int'(cycle_cnt) == val) ||
                (kind == 2 && !running))
                return;
        end
        check({"timeout ", what}, 0, 1);
    endtask

    int   m_len = 0;
    int   m_clk = 0;
    int   m_wp  = 0;
    int   m_bad = 0;
    exp_t m_e;

    always @(negedge clk) begin
        if (!running) begin
            if (tprend) check("tprend while idle", 1, 0);
            m_len = 0; m_clk = 0; m_wp = 0; m_bad = 0;
        end else begin
            m_len++;
            m_clk += int'(tpclk);
            m_wp  += int'(tpwp);
            if (tpwp && (phase < 6'd1 || phase > 6'd4)) m_bad = 1;
            if (tprend) begin
                if (sb.size() == 0) begin
                    check("unexpected tprend", 1, 0);
                end else begin
                    m_e = sb.pop_front();
                    check("cycle length", m_len, m_e.len);
                    check("tpclk high ticks", m_clk, m_e.clk_hi);
                    check("tpwp high ticks", m_wp, 4);
                    check("tpwp outside 1..4", m_bad, 0);
                    check("cycle_cnt at tprend", int'(cycle_cnt), m_e.cnt);
                end
                m_len = 0; m_clk = 0; m_wp = 0; m_bad = 0;
            end
        end
    end

    initial begin
        clock_reset_b = 1'b0;
        sspeed        = 2'd0;
        ilong         = 1'b0;
        machrun       = 1'b0;
        step          = 1'b0;
        hang          = 1'b0;
        wr_rst_b      = 1'b0;
        wr_machrun    = 1'b0;

        #12;
        check("reset running", int'(running), 0);
        check("reset phase", int'(phase), 0);
        check("reset cycle_cnt", int'(cycle_cnt), 0);
        check("reset tpclk", int'(tpclk), 0);
        check("reset tprend", int'(tprend), 0);
        check("reset tpwp", int'(tpwp), 0);

        @(posedge clk); #1;
        clock_reset_b = 1'b1;
        wr_rst_b      = 1'b1;
        @(posedge clk); #1;
        check("idle after reset", int'(running), 0);

        // Free run at L=32
        machrun = 1'b1;
        for (int i = 0; i < 4; i++) push(32, 16, i);
        repeat (97) @(posedge clk);
        #1;
        check("cycle_cnt after 96 ticks", int'(cycle_cnt), 3);
        check("phase after 96 ticks", int'(phase), 0);

        // Speed change mid-cycle takes effect at next start
        wait_for("phase 10", 0, 10);
        sspeed = 2'd3;
        ilong  = 1'b1;
        push(15, 7, 4);
        push(15, 7, 5);

        // Stall at last phase for 20 ticks
        wait_for("cnt 6", 1, 6);
        wait_for("phase 5", 0, 5);
        hang = 1'b1;
        push(35, 7, 6);
        wait_for("phase 14", 0, 14);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            check("hold phase", int'(phase), 14);
            check("hold tprend", int'(tprend), 0);
            check("hold tpwp", int'(tpwp), 0);
        end
        hang = 1'b0;
        #1;
        check("tprend on hang release", int'(tprend), 1);

        // Drop machrun mid-cycle
        wait_for("cnt 7", 1, 7);
        wait_for("phase 3", 0, 3);
        machrun = 1'b0;
        push(15, 7, 7);
        wait_for("idle after run", 2, 0);
        check("cnt after run stop", int'(cycle_cnt), 8);
        check("phase in idle", int'(phase), 0);

        // Single step at L=25, second step ignored
        sspeed = 2'd2;
        ilong  = 1'b0;
        step   = 1'b1;
        push(25, 12, 8);
        @(posedge clk); #1;
        step = 1'b0;
        check("step start running", int'(running), 1);
        check("step start phase", int'(phase), 0);
        wait_for("step phase 8", 0, 8);
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        wait_for("idle after step", 2, 0);
        check("cnt after step", int'(cycle_cnt), 9);
        repeat (5) @(posedge clk);
        #1;
        check("stays idle after step", int'(running), 0);

        // Reset mid-cycle aborts
        sspeed  = 2'd0;
        machrun = 1'b1;
        wait_for("phase 12", 0, 12);
        check("tpclk before abort", int'(tpclk), 1);
        clock_reset_b = 1'b0;
        #1;
        check("abort running", int'(running), 0);
        check("abort phase", int'(phase), 0);
        check("abort cycle_cnt", int'(cycle_cnt), 0);
        check("abort tpclk", int'(tpclk), 0);
        check("abort tprend", int'(tprend), 0);
        check("abort tpwp", int'(tpwp), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        clock_reset_b = 1'b1;
        push(32, 16, 0);
        @(posedge clk); #1;
        check("restart running", int'(running), 1);
        check("restart phase", int'(phase), 0);
        wait_for("restart phase 5", 0, 5);
        machrun = 1'b0;
        wait_for("idle after restart", 2, 0);
        check("cnt after restart", int'(cycle_cnt), 1);

        // Counter wrap with CYC_W=4: 17 cycles of L=15
        wr_machrun = 1'b1;
        repeat (256) @(posedge clk);
        #1;
        check("wrap cycle_cnt", int'(wr_cnt), 1);
        check("wrap phase", int'(wr_phase), 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
